// File: rtl/fir_pkg.sv
// fir_pkg: shared types, default widths and result formatting
// for the time-multiplexed streaming FIR core.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  localparam int FIR_DATA_W    = 16;
  localparam int FIR_COEF_W    = 16;
  localparam int FIR_TAPS      = 16;
  localparam int FIR_ACC_W     = 40;
  localparam int FIR_OUT_SHIFT = 15;

  // Smallest accumulator that cannot overflow over a full pass.
  function automatic int min_acc_w(
    input int dw,
    input int cw,
    input int taps
  );
    return dw + cw + $clog2(taps);
  endfunction

  function automatic logic signed [63:0] res_max(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] res_min(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

  // Clamp to the dw-bit signed range when sat is set; otherwise
  // pass through and let the caller wrap by truncation.
  function automatic logic signed [63:0] fmt_res(
    input logic signed [63:0] v,
    input int                 dw,
    input logic               sat
  );
    if (sat && (v > res_max(dw))) return res_max(dw);
    if (sat && (v < res_min(dw))) return res_min(dw);
    return v;
  endfunction

  function automatic logic is_clip(
    input logic signed [63:0] v,
    input int                 dw
  );
    return (v > res_max(dw)) || (v < res_min(dw));
  endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: full-precision signed multiply feeding a registered
// accumulator with synchronous clear and enable.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int COEF_W = FIR_COEF_W,
  parameter int ACC_W  = FIR_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PW = DATA_W + COEF_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_x;

  assign prod   = PW'(a) * PW'(b);
  assign prod_x = {{(ACC_W - PW){prod[PW-1]}}, prod};

  // Accumulate one product per enabled cycle; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_x;
    end
  end

endmodule

// File: rtl/fir_stream_core.sv
// fir_stream_core: streaming FIR, one MAC per cycle over a circular
// history. Define FIR_SAT_EN for saturating output and sat_flag.
module fir_stream_core
  import fir_pkg::*;
#(
  parameter int DATA_W    = FIR_DATA_W,
  parameter int COEF_W    = FIR_COEF_W,
  parameter int TAPS      = FIR_TAPS,
  parameter int ACC_W     = FIR_ACC_W,
  parameter int OUT_SHIFT = FIR_OUT_SHIFT
) (
  input  logic                       CLK_100M,
  input  logic                       RST_N,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       coef_drop,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_data,
  output logic                       busy
`ifdef FIR_SAT_EN
  ,
  output logic                       sat_flag
`endif
);

  localparam int AW = $clog2(TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

`ifdef FIR_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  state_t state_q, state_d;

  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [DATA_W-1:0] hist [TAPS];

  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           k;
  logic [AW-1:0]           rd_idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [63:0]      acc64;
  logic signed [63:0]      shifted;
  logic signed [63:0]      res;
  logic                    accept;
  logic                    last;
  logic                    mac_en;
  logic                    cwr;

  assign accept    = (state_q == IDLE) && in_valid && in_ready;
  assign last      = (k == LAST);
  assign mac_en    = (state_q == MAC);
  assign rd_idx    = wr_ptr - k;
  assign cwr       = coef_we && (state_q == IDLE);
  assign coef_drop = coef_we && (state_q != IDLE);
  assign busy      = (state_q != IDLE);

  assign acc64   = {{(64 - ACC_W){acc[ACC_W-1]}}, acc};
  assign shifted = acc64 >>> OUT_SHIFT;
  assign res     = fmt_res(shifted, DATA_W, SAT);

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (CLK_100M),
    .rst_n (RST_N),
    .clr   (accept),
    .en    (mac_en),
    .a     (hist[rd_idx]),
    .b     (coef[k]),
    .acc   (acc)
  );

  // State register.
  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept -> TAPS MAC cycles -> hold result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (last) state_d = OUT;
      OUT:     if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tap counter, write pointer and registered in_ready.
  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      k        <= '0;
      in_ready <= 1'b0;
    end else begin
      in_ready <= (state_d == IDLE);
      if (accept) begin
        k <= '0;
      end else if (state_q == MAC) begin
        k <= k + AW'(1);
        if (last) wr_ptr <= wr_ptr + AW'(1);
      end
    end
  end

  // Coefficient RAM, writable only while idle.
  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else if (cwr) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // Sample history, newest sample lands at wr_ptr.
  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < TAPS; i++) hist[i] <= '0;
    end else if (accept) begin
      hist[wr_ptr] <= in_data;
    end
  end

  // Result register: load once on entering OUT, hold until taken.
  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef FIR_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else if (state_q == OUT) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_data  <= DATA_W'(res);
`ifdef FIR_SAT_EN
        sat_flag  <= is_clip(shifted, DATA_W);
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_core.sv
// tb_fir_stream_core: directed checks of fir_stream_core with
// default parameters (TAPS=16, OUT_SHIFT=15).
module tb_fir_stream_core;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int AW = 4;

  logic          CLK_100M = 1'b0;
  logic          RST_N = 1'b1;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic          coef_drop;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          busy;
`ifdef FIR_SAT_EN
  logic          sat_flag;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  fir_stream_core dut (
    .CLK_100M  (CLK_100M),
    .RST_N     (RST_N),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_drop (coef_drop),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef FIR_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  always #5 CLK_100M = ~CLK_100M;

  always @(posedge CLK_100M) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK_100M);
    RST_N = 1'b0;
    in_valid = 1'b0;
    coef_we = 1'b0;
    repeat (3) @(negedge CLK_100M);
    RST_N = 1'b1;
    @(negedge CLK_100M);
  endtask

  task automatic send(input logic [DW-1:0] x, output int acc_cyc);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge CLK_100M);
      n++;
    end
    check("send_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data = x;
    @(posedge CLK_100M);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    @(negedge CLK_100M);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge CLK_100M);
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
  endtask

  task automatic get(
    input logic [DW-1:0] exp,
    input string         tag,
    input int            acc_cyc,
    input bit            exp_sat
  );
    wait_valid(tag);
    check({tag, "_lat"}, cyc - acc_cyc, 17);
    check(tag, out_data, exp);
`ifdef FIR_SAT_EN
    check({tag, "_sat"}, sat_flag, exp_sat);
`else
    if (exp_sat) check({tag, "_nosat"}, out_data, exp);
`endif
    out_ready = 1'b1;
    @(posedge CLK_100M);
    @(negedge CLK_100M);
  endtask

  initial begin
    int a;
    int acc_at [4];
    int nacc;
    int npulse;
    logic [DW-1:0] e;
    bit es;

    // reset values
    #2 RST_N = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_coef_drop", coef_drop, 0);
    repeat (2) @(negedge CLK_100M);
    RST_N = 1'b1;
    #1 check("rel_in_ready0", in_ready, 0);
    @(negedge CLK_100M);
    check("rel_in_ready1", in_ready, 1);

    // h[k] = k+1
    for (int k = 0; k < 16; k++) begin
      coef_we = 1'b1;
      coef_addr = AW'(k);
      coef_data = CW'(k + 1);
      #1;
      if (k == 0) check("idle_no_drop", coef_drop, 0);
      @(negedge CLK_100M);
    end
    coef_we = 1'b0;
    out_ready = 1'b1;

    // impulse of -32768, shift 15: y[n] = -(n+1), then 0
    for (int n = 0; n < 17; n++) begin
      send((n == 0) ? 16'h8000 : 16'h0000, a);
      e = (n < 16) ? DW'(-(n + 1)) : 16'h0000;
      get(e, $sformatf("imp%0d", n), a, 1'b0);
    end

    // backpressure: y = -1 held while out_ready low
    out_ready = 1'b0;
    send(16'h8000, a);
    wait_valid("bp");
    in_valid = 1'b1;
    in_data = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK_100M);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 16'hFFFF);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge CLK_100M);
    check("bp_drop", out_valid, 0);
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_busy", busy, 0);
    @(negedge CLK_100M);
    check("bp_taken_busy", busy, 1);
    in_valid = 1'b0;
    a = cyc;
    get(16'hFFFE, "bp_next", a, 1'b0);

    // coefficient write during MAC is dropped
    send(16'h8000, a);
    repeat (2) @(negedge CLK_100M);
    coef_we = 1'b1;
    coef_addr = '0;
    coef_data = 16'd100;
    #1 check("cd_pulse", coef_drop, 1);
    @(negedge CLK_100M);
    coef_we = 1'b0;
    #1 check("cd_pulse_end", coef_drop, 0);
    get(16'hFFFC, "cd_cur", a, 1'b0);
    send(16'h8000, a);
    get(16'hFFF9, "cd_next", a, 1'b0);

    // reset in the middle of MAC
    send(16'h8000, a);
    repeat (6) @(negedge CLK_100M);
    #2 RST_N = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_data", out_data, 0);
    check("mrst_in_ready", in_ready, 0);
    repeat (3) @(negedge CLK_100M);
    check("mrst_hold_valid", out_valid, 0);
    RST_N = 1'b1;
    @(negedge CLK_100M);
    send(16'h8000, a);
    get(16'h0000, "mrst_imp0", a, 1'b0);
    send(16'h0000, a);
    get(16'h0000, "mrst_imp1", a, 1'b0);

    // wrap vs saturate: all h and x = 32767
    do_reset();
    for (int k = 0; k < 16; k++) begin
      coef_we = 1'b1;
      coef_addr = AW'(k);
      coef_data = 16'h7FFF;
      @(negedge CLK_100M);
    end
    coef_we = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      send(16'h7FFF, a);
`ifdef FIR_SAT_EN
      e = (j == 1) ? 16'h7FFE : 16'h7FFF;
      es = (j != 1);
`else
      e = DW'(j * 32766);
      es = 1'b0;
`endif
      get(e, $sformatf("wrap%0d", j), a, es);
    end

    // throughput with in_valid and out_ready held high
    nacc = 0;
    npulse = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge CLK_100M);
      if (out_valid) npulse++;
      if (nacc < 4 && in_ready) begin
        in_valid = 1'b1;
        in_data = 16'h0000;
        acc_at[nacc] = cyc + 1;
        nacc++;
      end else if (nacc == 4 && !in_ready) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("tp_accepts", nacc, 4);
    check("tp_pulses", npulse, 4);
    for (int i = 0; i < 3; i++)
      check($sformatf("tp_gap%0d", i), acc_at[i+1] - acc_at[i], 19);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_stream_core.md
Name: fir_stream_core

Overview:
- Streaming, time-multiplexed FIR filter in the 100 MHz domain, fed by the CPU subsystem and returning results to it.
- The CPU loads coefficients and pushes samples over a valid/ready stream. Filtered results come back on a second valid/ready stream.
- One multiply-accumulate per cycle over a circular sample history.
- Sits directly downstream of the CPU subsystem on the CLK_100M clock from the PLL.

Parameters:
- DATA_W, 16, signed sample and result width.
- COEF_W, 16, signed coefficient width.
- TAPS, 16, number of taps; power of two, minimum 2.
- ACC_W, 40, signed accumulator width; must be at least DATA_W+COEF_W+log2(TAPS).
- OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before output.

Ports:
- CLK_100M  in  1  system clock.
- RST_N  in  1  reset.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  log2(TAPS)  coefficient index k.
- coef_data  in  COEF_W  signed coefficient h[k].
- coef_drop  out  1  one-cycle pulse: a write was rejected.
- in_valid  in  1  sample valid.
- in_ready  out  1  core can accept a sample.
- in_data  in  DATA_W  signed sample x[n].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  signed result y[n].
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset:
  - Clock is CLK_100M; reset is RST_N, asynchronous assert, active-low. Deassertion is synchronised externally.
  - On reset, all coefficients, the sample history, the write pointer and the accumulator are cleared to 0. State goes to IDLE.
  - Output reset values: in_ready=0, out_valid=0, out_data=0, busy=0, coef_drop=0.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1 (registered; it is 1 in the first cycle after reset release).
  - A sample is accepted on an edge where in_valid and in_ready are both 1.
  - On accept: write in_data to hist[wr_ptr], clear acc, set k=0, go to MAC.
- MAC:
  - Lasts exactly TAPS cycles. Each cycle: acc += hist[(wr_ptr-k) mod TAPS] * h[k], then k++.
  - Products are full DATA_W+COEF_W signed, sign-extended to ACC_W.
  - After the last tap, wr_ptr increments (wrapping at TAPS), out_data is registered, and the state goes to OUT.
- OUT:
  - out_valid=1; out_data is held stable until handshake.
  - On out_valid and out_ready both 1: out_valid drops, state goes to IDLE.
- Latency and throughput:
  - out_valid rises TAPS+1 edges after the accepting edge.
  - With out_ready tied high, the next sample is accepted TAPS+3 edges after the previous one.
- Result formatting:
  - res = acc >>> OUT_SHIFT (arithmetic shift, truncation toward minus infinity).
  - res is then truncated to the low DATA_W bits (two's-complement wrap).
- Coefficient writes:
  - Honoured only in IDLE, and take effect for the next accepted sample.
  - A write in IDLE and a sample accept on the same edge are both honoured; the new coefficient applies to that sample.
  - coef_we in MAC or OUT is ignored and coef_drop pulses high for exactly that cycle.
- Sample history:
  - Wraps modulo TAPS.
  - Before TAPS samples have arrived, the missing history entries are the reset zeros.
- Reset during MAC or OUT: the operation is abandoned immediately; no out_valid is produced.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined: res saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1] instead of wrapping, and output port sat_flag (out, 1) is added. sat_flag is registered with out_data, high when clipping occurred, and reset to 0.
- Undefined: wrap behaviour as above; there is no sat_flag port.

Decomposition:
- Package fir_pkg:
  - FSM state enum (IDLE, MAC, OUT).
  - Default width constants and a function returning the minimum ACC_W.
  - The saturate/wrap formatting function.
- Sub-module fir_mac: signed multiplier plus accumulator with clear and enable, registered, parameterised by DATA_W, COEF_W and ACC_W.
- fir_stream_core owns the FSM, coefficient RAM, history RAM and pointers.

Test Plan:
- Impulse response (OUT_SHIFT=0, h[k]=k+1): send 1 followed by 16 zeros -> out_data sequence 1,2,…,16 then 0. Each out_valid comes 17 edges after its accept.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid stays 1, out_data stays stable, in_ready stays 0. A result is accepted, and the next sample taken, only after out_ready rises.
- Wrap vs saturate (OUT_SHIFT=15, all h=32767, 16 inputs of 32767): without FIR_SAT_EN the 16th output is 0xFFE0 (-32). With FIR_SAT_EN it is 32767 and sat_flag=1.
- Coefficient write during MAC: coef_drop pulses for exactly 1 cycle; the current and next outputs are computed with the old h[k].
- Reset asserted at MAC cycle 7: all outputs return to reset values asynchronously. After release, an impulse input produces an all-zero response because coefficients were cleared.
- Throughput (TAPS=16, out_ready=1, in_valid=1 continuously): accepts occur every 19 cycles; 4 accepts produce exactly 4 out_valid pulses.
